// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard query bundle: D-stage operand/producer info in,
// stall and per-consumer forward selects out.
interface hazard_scoreboard_if #(
  parameter int REG_W = 6,
  parameter int NSTG  = 3
);
  localparam int SEL_W = $clog2(NSTG + 1);

  logic [REG_W-1:0] A1D;
  logic [REG_W-1:0] A2D;
  logic [REG_W-1:0] A3D;
  logic [1:0]       TuseRS;
  logic [1:0]       TuseRT;
  logic [1:0]       TnewD;
  logic             MdStart;
  logic             MdUse;
  logic             Flush;
  logic             Stall;
  logic [SEL_W-1:0] Fwd_RS_D;
  logic [SEL_W-1:0] Fwd_RT_D;
  logic [SEL_W-1:0] Fwd_RS_E;
  logic [SEL_W-1:0] Fwd_RT_E;
  logic [SEL_W-1:0] Fwd_RT_M;

  modport master (
    output A1D, A2D, A3D, TuseRS, TuseRT, TnewD, MdStart, MdUse, Flush,
    input  Stall, Fwd_RS_D, Fwd_RT_D, Fwd_RS_E, Fwd_RT_E, Fwd_RT_M
  );

  modport slave (
    input  A1D, A2D, A3D, TuseRS, TuseRT, TnewD, MdStart, MdUse, Flush,
    output Stall, Fwd_RS_D, Fwd_RT_D, Fwd_RS_E, Fwd_RT_E, Fwd_RT_M
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks sources, destination and result readiness of in-flight instructions
// after D, and resolves D-stage stalls (data and mul/div busy) plus forward selects.
module hazard_scoreboard #(
  parameter int REG_W   = 6,
  parameter int NSTG    = 3,
  parameter int MDU_LAT = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  hazard_scoreboard_if.slave hif
);
  localparam int         SEL_W     = $clog2(NSTG + 1);
  localparam logic [4:0] MDU_LAT_V = 5'(MDU_LAT);

  logic [REG_W-1:0] a1_q   [1:NSTG];
  logic [REG_W-1:0] a1_d   [1:NSTG];
  logic [REG_W-1:0] a2_q   [1:NSTG];
  logic [REG_W-1:0] a2_d   [1:NSTG];
  logic [REG_W-1:0] a3_q   [1:NSTG];
  logic [REG_W-1:0] a3_d   [1:NSTG];
  logic [1:0]       tnew_q [1:NSTG];
  logic [1:0]       tnew_d [1:NSTG];
  logic             md1_q, md1_d;
  logic [4:0]       mdu_cnt_q, mdu_cnt_d;

  logic             data_stall;
  logic             mdu_stall;
  logic             stall;
  logic [SEL_W-1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  always_comb begin
    data_stall = 1'b0;
    for (int k = 1; k <= NSTG; k++) begin
      if (hif.A1D != '0 && hif.A1D == a3_q[k] && tnew_q[k] > hif.TuseRS) data_stall = 1'b1;
      if (hif.A2D != '0 && hif.A2D == a3_q[k] && tnew_q[k] > hif.TuseRT) data_stall = 1'b1;
    end
    mdu_stall = hif.MdUse && (mdu_cnt_q != 5'd0 || md1_q);
    stall     = data_stall || mdu_stall;
  end

  // Walk oldest to youngest so the youngest matching producer has the final say;
  // a match whose result is not ready yet forces the select back to the register file.
  always_comb begin
    fwd_rs_d = '0;
    fwd_rt_d = '0;
    fwd_rs_e = '0;
    fwd_rt_e = '0;
    fwd_rt_m = '0;
    for (int k = NSTG; k >= 1; k--) begin
      if (hif.A1D != '0 && hif.A1D == a3_q[k])
        fwd_rs_d = (tnew_q[k] == 2'd0) ? SEL_W'(k) : '0;
      if (hif.A2D != '0 && hif.A2D == a3_q[k])
        fwd_rt_d = (tnew_q[k] == 2'd0) ? SEL_W'(k) : '0;
      if (k >= 2 && a1_q[1] != '0 && a1_q[1] == a3_q[k])
        fwd_rs_e = (tnew_q[k] == 2'd0) ? SEL_W'(k) : '0;
      if (k >= 2 && a2_q[1] != '0 && a2_q[1] == a3_q[k])
        fwd_rt_e = (tnew_q[k] == 2'd0) ? SEL_W'(k) : '0;
      if (k >= 3 && a2_q[2] != '0 && a2_q[2] == a3_q[k])
        fwd_rt_m = (tnew_q[k] == 2'd0) ? SEL_W'(k) : '0;
    end
  end

  always_comb begin
    for (int k = 1; k <= NSTG; k++) begin
      a1_d[k]   = '0;
      a2_d[k]   = '0;
      a3_d[k]   = '0;
      tnew_d[k] = 2'd0;
    end
    md1_d = 1'b0;
    if (!hif.Flush) begin
      if (!stall) begin
        a1_d[1]   = hif.A1D;
        a2_d[1]   = hif.A2D;
        a3_d[1]   = hif.A3D;
        tnew_d[1] = hif.TnewD;
        md1_d     = hif.MdStart;
      end
      for (int k = 2; k <= NSTG; k++) begin
        a1_d[k]   = a1_q[k-1];
        a2_d[k]   = a2_q[k-1];
        a3_d[k]   = a3_q[k-1];
        tnew_d[k] = (tnew_q[k-1] == 2'd0) ? 2'd0 : tnew_q[k-1] - 2'd1;
      end
    end
    // Flush does not cancel a mul/div already running in the unit.
    if (hif.MdStart && !stall && !hif.Flush) mdu_cnt_d = MDU_LAT_V;
    else if (mdu_cnt_q != 5'd0)               mdu_cnt_d = mdu_cnt_q - 5'd1;
    else                                      mdu_cnt_d = 5'd0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 1; k <= NSTG; k++) begin
        a1_q[k]   <= '0;
        a2_q[k]   <= '0;
        a3_q[k]   <= '0;
        tnew_q[k] <= 2'd0;
      end
      md1_q     <= 1'b0;
      mdu_cnt_q <= 5'd0;
    end else begin
      for (int k = 1; k <= NSTG; k++) begin
        a1_q[k]   <= a1_d[k];
        a2_q[k]   <= a2_d[k];
        a3_q[k]   <= a3_d[k];
        tnew_q[k] <= tnew_d[k];
      end
      md1_q     <= md1_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign hif.Stall    = stall;
  assign hif.Fwd_RS_D = fwd_rs_d;
  assign hif.Fwd_RT_D = fwd_rt_d;
  assign hif.Fwd_RS_E = fwd_rs_e;
  assign hif.Fwd_RT_E = fwd_rt_e;
  assign hif.Fwd_RT_M = fwd_rt_m;
endmodule
